// File: rtl/stone_age_emitter_pkg.sv
// Shared definitions for the stone-age unit emitter.
//
// Contents:
//   DEFAULT_WIDTH - default binary count width (LED bar of 2**WIDTH-1 lamps)
//   state_t       - emitter FSM state encoding
//   max_int       - larger of two integers, used to size the tick counter
//   cnt_width     - bits needed to count 0..max_count-1 (at least one bit)
package stone_age_emitter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE_HI = 2'd1,
        ST_PULSE_LO = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The tick counter only ever holds 0..max_count-1, so $clog2(max_count)
    // bits suffice; a single-tick phase still needs one physical bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/stone_age_emitter_therm_encode.sv
// Binary-to-thermometer encoder.
//
// Ports:
//   bin   [WIDTH-1:0]     - binary value r, 0..2**WIDTH-1
//   therm [2**WIDTH-2:0]  - bits [r-1:0] set, all others clear
//
// Purely combinational; shared between the emitter's LED load path and the
// display top.
module therm_encode
    import stone_age_emitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [2**WIDTH-2:0] therm
);

    always_comb begin
        therm = '0;
        for (int i = 0; i < 2**WIDTH - 1; i++) begin
            if (i < int'(bin)) begin
                therm[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stone_age_emitter.sv
// Stone-age unit emitter: turns a binary count into a stream of that many
// high pulses, paced by a slow clock-enable, while showing the units still
// to go as a thermometer LED bar and as a binary count.
//
// Parameters:
//   WIDTH    - binary count width; LED bar has 2**WIDTH-1 lamps
//   HI_TICKS - tick periods the pulse stays high per unit
//   LO_TICKS - tick periods the pulse stays low between units
//
// Ports:
//   CLK        in   system clock, all registers on the rising edge
//   RST        in   synchronous active-high reset
//   tick       in   one-CLK-wide pacing enable from the clock divider
//   start      in   request to emit num_in units (taken only when ready)
//   num_in     in   binary unit count
//   ready      out  high only while idle
//   busy       out  high while emitting (pulse high or low phase)
//   done       out  one-CLK strobe after the last unit (or an empty request)
//   pulse      out  unit stream, one high pulse per unit
//   led        out  thermometer of units not yet emitted
//   remaining  out  binary count of units not yet emitted
//
// Every output is a register written by the FSM, so nothing on the outputs
// is decoded combinationally from the inputs.
module stone_age_emitter
    import stone_age_emitter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int HI_TICKS = 1,
    parameter int LO_TICKS = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                tick,
    input  logic                start,
    input  logic [WIDTH-1:0]    num_in,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                pulse,
    output logic [2**WIDTH-2:0] led,
    output logic [WIDTH-1:0]    remaining
);

    localparam int LED_W   = 2**WIDTH - 1;
    localparam int CNT_MAX = max_int(HI_TICKS, LO_TICKS);
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_TICKS - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_TICKS - 1);

    state_t             state_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               pulse_q;
    logic [LED_W-1:0]   led_q;
    logic [WIDTH-1:0]   remaining_q;
    logic [CNT_W-1:0]   cnt_q;

    // Thermometer pattern of the incoming request, loaded on acceptance.
    logic [LED_W-1:0]   led_load_d;

    therm_encode #(
        .WIDTH (WIDTH)
    ) u_therm (
        .bin   (num_in),
        .therm (led_load_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_q     <= 1'b0;
            led_q       <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                // Ticks are ignored here, so a tick on the accepting edge
                // never counts toward the first high phase.
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= num_in;
                        led_q       <= led_load_d;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        if (num_in != '0) begin
                            state_q <= ST_PULSE_HI;
                            busy_q  <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                // End of a high phase retires one unit; because led is always
                // a thermometer of remaining, a right shift clears exactly
                // bit [remaining-1].
                ST_PULSE_HI: begin
                    if (tick) begin
                        if (cnt_q == HI_LAST) begin
                            state_q     <= ST_PULSE_LO;
                            pulse_q     <= 1'b0;
                            remaining_q <= remaining_q - 1'b1;
                            led_q       <= led_q >> 1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                // remaining is at least 1 whenever PULSE_HI is entered, so
                // the decrement above can never wrap.
                ST_PULSE_LO: begin
                    if (tick) begin
                        if (cnt_q == LO_LAST) begin
                            cnt_q <= '0;
                            if (remaining_q != '0) begin
                                state_q <= ST_PULSE_HI;
                                pulse_q <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pulse_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse     = pulse_q;
    assign led       = led_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_stone_age_emitter.sv
// Directed bench for stone_age_emitter: one default-parameter instance and
// one with HI_TICKS=3 / LO_TICKS=2 sharing clock, reset, tick and num_in.
module tb_stone_age_emitter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst     = 1'b1;
    logic        tick    = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [3:0]  num_in  = 4'd0;

    logic        a_ready, a_busy, a_done, a_pulse;
    logic [14:0] a_led;
    logic [3:0]  a_rem;
    logic        b_ready, b_busy, b_done, b_pulse;
    logic [14:0] b_led;
    logic [3:0]  b_rem;

    stone_age_emitter #(.WIDTH(4)) dut_a (
        .CLK(CLK), .RST(rst), .tick(tick), .start(start_a), .num_in(num_in),
        .ready(a_ready), .busy(a_busy), .done(a_done), .pulse(a_pulse),
        .led(a_led), .remaining(a_rem)
    );

    stone_age_emitter #(.WIDTH(4), .HI_TICKS(3), .LO_TICKS(2)) dut_b (
        .CLK(CLK), .RST(rst), .tick(tick), .start(start_b), .num_in(num_in),
        .ready(b_ready), .busy(b_busy), .done(b_done), .pulse(b_pulse),
        .led(b_led), .remaining(b_rem)
    );

    // Observed instance selected by sel.
    bit          sel = 1'b0;
    logic        o_ready, o_busy, o_done, o_pulse;
    logic [14:0] o_led;
    logic [3:0]  o_rem;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_pulse = sel ? b_pulse : a_pulse;
    assign o_led   = sel ? b_led   : a_led;
    assign o_rem   = sel ? b_rem   : a_rem;

    int n_cmp = 0;
    int n_err = 0;

    // Per-run statistics filled by emit().
    int          n_pulses, n_dones, therm_bad, underflow, first_done, cyc_count;
    int          hi_len[$];
    int          lo_len[$];
    logic [14:0] led_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    // Issues one request of n units on instance s, ticking every te cycles
    // (a tick also coincides with the accepting edge), and samples every
    // cycle until ready returns or the budget runs out. Optionally re-issues
    // start with 9 at cycle restart_at, and asserts reset (with start high)
    // once rst_after pulses have completed.
    task automatic emit(input bit s, input logic [3:0] n, input int te, input int budget,
                        input int restart_at, input int rst_after);
        int          cyc;
        int          cur_hi;
        int          cur_lo;
        logic        prev_pulse;
        logic [3:0]  prev_rem;
        logic [14:0] last_led;
        bit          rst_pending;
        bit          rst_fired;
        sel = s;
        #0;
        n_pulses = 0; n_dones = 0; therm_bad = 0; underflow = 0; first_done = -1;
        hi_len.delete(); lo_len.delete(); led_hist.delete();
        cur_hi = 0; cur_lo = 0; prev_pulse = 1'b0; prev_rem = n; last_led = o_led;
        rst_pending = 1'b0; rst_fired = 1'b0;
        cyc = 0;
        do begin
            if (rst_pending) begin
                rst    = 1'b1;
                num_in = 4'd7;
                set_start(s, 1'b1);
            end else if (cyc == 0) begin
                num_in = n;
                set_start(s, 1'b1);
            end else if (restart_at != 0 && cyc == restart_at) begin
                num_in = 4'd9;
                set_start(s, 1'b1);
            end else begin
                set_start(s, 1'b0);
            end
            tick = (cyc % te == 0);
            @(posedge CLK);
            #1;
            if (rst_pending) begin
                rst         = 1'b0;
                rst_pending = 1'b0;
                rst_fired   = 1'b1;
            end
            if (o_led !== ((15'd1 << o_rem) - 15'd1)) therm_bad++;
            if (o_rem > prev_rem) underflow++;
            prev_rem = o_rem;
            if (o_pulse && !prev_pulse) n_pulses++;
            prev_pulse = o_pulse;
            if (o_done) begin
                n_dones++;
                if (first_done < 0) first_done = cyc;
            end
            if (o_pulse) cur_hi++;
            else if (cur_hi > 0) begin hi_len.push_back(cur_hi); cur_hi = 0; end
            if (o_busy && !o_pulse) cur_lo++;
            else if (cur_lo > 0) begin lo_len.push_back(cur_lo); cur_lo = 0; end
            if (o_led !== last_led) begin
                led_hist.push_back(o_led);
                last_led = o_led;
            end
            if (!rst_fired && rst_after != 0 && n_pulses == rst_after && !o_pulse)
                rst_pending = 1'b1;
            cyc++;
        end while (!o_ready && cyc < budget);
        if (cur_hi > 0) hi_len.push_back(cur_hi);
        if (cur_lo > 0) lo_len.push_back(cur_lo);
        set_start(s, 1'b0);
        tick      = 1'b0;
        cyc_count = cyc;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        // Reset with start and tick held high: both must be ignored.
        rst = 1'b1; start_a = 1'b1; num_in = 4'd5; tick = 1'b1;
        idle_cycles(2);
        chk("rst_ready",  a_ready, 1);
        chk("rst_busy",   a_busy,  0);
        chk("rst_done",   a_done,  0);
        chk("rst_pulse",  a_pulse, 0);
        chk("rst_led",    a_led,   0);
        chk("rst_rem",    a_rem,   0);
        chk("rst_b_ready", b_ready, 1);
        rst = 1'b0; start_a = 1'b0; tick = 1'b0;
        idle_cycles(1);
        chk("post_rst_rem",  a_rem,  0);
        chk("post_rst_busy", a_busy, 0);

        // Three units, tick every 4 CLK: 4 cycles high, 4 low, per unit.
        emit(1'b0, 4'd3, 4, 100, 0, 0);
        chk("n3_ready_end", o_ready, 1);
        chk("n3_pulses",    n_pulses, 3);
        chk("n3_dones",     n_dones, 1);
        chk("n3_first_done", first_done, 24);
        chk("n3_cycles",    cyc_count, 26);
        chk("n3_therm_bad", therm_bad, 0);
        chk("n3_hist_size", led_hist.size(), 4);
        chk("n3_hist0",     led_hist[0], 15'h0007);
        chk("n3_hist1",     led_hist[1], 15'h0003);
        chk("n3_hist2",     led_hist[2], 15'h0001);
        chk("n3_hist3",     led_hist[3], 15'h0000);
        chk("n3_hi_runs",   hi_len.size(), 3);
        chk("n3_hi_len",    hi_len[0], 4);
        chk("n3_lo_len",    lo_len[0], 4);

        // Empty request: straight to DONE, no pulse, LEDs stay dark.
        emit(1'b0, 4'd0, 1, 20, 0, 0);
        chk("n0_ready_end",  o_ready, 1);
        chk("n0_pulses",     n_pulses, 0);
        chk("n0_dones",      n_dones, 1);
        chk("n0_first_done", first_done, 0);
        chk("n0_cycles",     cyc_count, 2);
        chk("n0_led_moved",  led_hist.size(), 0);

        // Full scale with defaults.
        emit(1'b0, 4'd15, 1, 100, 0, 0);
        chk("n15_ready_end",  o_ready, 1);
        chk("n15_pulses",     n_pulses, 15);
        chk("n15_dones",      n_dones, 1);
        chk("n15_underflow",  underflow, 0);
        chk("n15_therm_bad",  therm_bad, 0);
        chk("n15_led_start",  led_hist[0], 15'h7FFF);
        chk("n15_hist_size",  led_hist.size(), 16);
        chk("n15_first_done", first_done, 30);
        chk("n15_hi_runs",    hi_len.size(), 15);
        chk("n15_lo_runs",    lo_len.size(), 15);
        chk("n15_hi_len",     hi_len[0], 1);
        chk("n15_rem_end",    o_rem, 0);

        // Second request during busy is dropped, not queued.
        emit(1'b0, 4'd5, 1, 100, 3, 0);
        chk("n5_ready_end", o_ready, 1);
        chk("n5_pulses",    n_pulses, 5);
        chk("n5_dones",     n_dones, 1);
        chk("n5_underflow", underflow, 0);
        chk("n5_led_start", led_hist[0], 15'h001F);
        idle_cycles(3);
        chk("n5_no_requeue_busy", o_busy, 0);
        chk("n5_no_requeue_rem",  o_rem, 0);
        chk("n5_no_requeue_rdy",  o_ready, 1);

        // Reset after the second of six pulses aborts without done.
        emit(1'b0, 4'd6, 1, 100, 0, 2);
        chk("abort_ready",  o_ready, 1);
        chk("abort_busy",   o_busy, 0);
        chk("abort_done",   o_done, 0);
        chk("abort_pulse",  o_pulse, 0);
        chk("abort_led",    o_led, 0);
        chk("abort_rem",    o_rem, 0);
        chk("abort_pulses", n_pulses, 2);
        chk("abort_dones",  n_dones, 0);
        chk("abort_cycles", cyc_count, 5);
        idle_cycles(2);
        chk("abort_idle_done", o_done, 0);
        chk("abort_idle_busy", o_busy, 0);

        // Longer phases: 3 ticks high, 2 low, two units, tick every cycle.
        emit(1'b1, 4'd2, 1, 100, 0, 0);
        chk("ht_ready_end",  o_ready, 1);
        chk("ht_pulses",     n_pulses, 2);
        chk("ht_dones",      n_dones, 1);
        chk("ht_hi_runs",    hi_len.size(), 2);
        chk("ht_hi0",        hi_len[0], 3);
        chk("ht_hi1",        hi_len[1], 3);
        chk("ht_lo_runs",    lo_len.size(), 2);
        chk("ht_lo0",        lo_len[0], 2);
        chk("ht_lo1",        lo_len[1], 2);
        chk("ht_first_done", first_done, 10);
        chk("ht_therm_bad",  therm_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
